// File: rtl/seq_detect_pkg.sv
// Shared types and elaboration-time helpers for the parametrised serial sequence detector.
`default_nettype none

package seq_detect_pkg;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } det_mode_e;

    localparam int MAX_PATTERN_W = 16;

    function automatic int state_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // Next matched-prefix length after taking bit_in from prefix length k.
    // A full-length match is excluded; the caller decides where a completed match goes.
    function automatic int prefix_fallback(input logic [MAX_PATTERN_W-1:0] pattern,
                                           input int width, input int k, input logic bit_in);
        int   best;
        int   idx;
        logic ok;
        logic sb;
        best = 0;
        for (int j = 1; j <= k + 1; j++) begin
            if (j < width) begin
                ok = 1'b1;
                for (int m = 0; m < j; m++) begin
                    idx = k + 1 - j + m;
                    sb  = (idx == k) ? bit_in : pattern[width-1-idx];
                    if (sb != pattern[width-1-m]) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int border_len(input logic [MAX_PATTERN_W-1:0] pattern, input int width);
        int   best;
        logic ok;
        best = 0;
        for (int l = 1; l < width; l++) begin
            ok = 1'b1;
            for (int m = 0; m < l; m++) begin
                if (pattern[width-1-m] != pattern[width-1-(width-l+m)]) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return best;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with KMP fallback, runtime overlap mode and match counter.
// Optional macro SEQDET_REGOUT_EN registers the match output one cycle after the completing bit.
`default_nettype none

module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1010,
    parameter int                   CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         din,
    input  logic                         din_valid,
    input  logic                         overlap_en,
    input  logic                         cnt_clr,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic [$clog2(PATTERN_W)-1:0] state_o
);

    localparam int                     SW     = state_width(PATTERN_W);
    localparam logic [MAX_PATTERN_W-1:0] PAT16 = MAX_PATTERN_W'(PATTERN);
    localparam int                     BORDER = border_len(PAT16, PATTERN_W);

    logic [SW-1:0]        state;
    logic [SW-1:0]        state_nxt;
    logic [SW-1:0]        idx;
    logic [SW-1:0]        fb0 [PATTERN_W];
    logic [SW-1:0]        fb1 [PATTERN_W];
    logic [PATTERN_W-1:0] exp_vec;
    logic                 in_range;
    logic                 expected;
    logic                 hit;
    det_mode_e            mode;

    assign mode = det_mode_e'(overlap_en);

    // Per-state transition table; every entry is folded to a constant at elaboration.
    for (genvar k = 0; k < PATTERN_W; k++) begin : g_tbl
        localparam logic [SW-1:0] FB0 = SW'(prefix_fallback(PAT16, PATTERN_W, k, 1'b0));
        localparam logic [SW-1:0] FB1 = SW'(prefix_fallback(PAT16, PATTERN_W, k, 1'b1));
        assign fb0[k]     = FB0;
        assign fb1[k]     = FB1;
        assign exp_vec[k] = PATTERN[PATTERN_W-1-k];
    end

    always_comb begin
        in_range  = (int'(state) < PATTERN_W);
        idx       = in_range ? state : '0;
        expected  = exp_vec[idx];
        hit       = din_valid & in_range & (din == expected) & (state == SW'(PATTERN_W - 1));
        state_nxt = state;
        if (!in_range) begin
            state_nxt = '0;
        end else if (din_valid) begin
            if (hit) begin
                state_nxt = (mode == MODE_OVL) ? SW'(BORDER) : '0;
            end else begin
                state_nxt = din ? fb1[idx] : fb0[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= '0;
        end else begin
            state <= state_nxt;
        end
    end

    assign state_o = state;

`ifdef SEQDET_REGOUT_EN
    logic match_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= hit;
        end
    end

    assign match = match_q;
`else
    assign match = hit;
`endif

    // Counting follows the completing bit, independent of output registering.
    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (hit),
        .clr  (cnt_clr),
        .count(match_cnt)
    );

endmodule

`default_nettype wire

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial sequence detector; successor to the fixed 4-bit Mealy "1010" detectors in the FSM library.
- Detects an arbitrary PATTERN of PATTERN_W bits on a 1-bit serial stream.
- Sampling is gated by a valid qualifier, so one instance serves both continuous and bursty streams.
- Overlap vs non-overlap is a runtime mode; a saturating match counter is provided for status/debug.

Parameters:
- PATTERN_W, 4, pattern length in bits, legal range 2..16.
- PATTERN, 4'b1010, target sequence; MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled only on cycles where this is 1.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match  output  1  pattern completed by the current din (Mealy output).
- match_cnt  output  CNT_W  number of matches, saturating.
- state_o  output  $clog2(PATTERN_W)  current matched-prefix length, for debug.

Behaviour:
- Reset: asynchronous, active-high.
  - state=0, match_cnt=0, match=0.
  - Reset mid-stream discards any partial match; no match may be reported for bits received before reset deasserted.
- State encoding: state = k means the last k accepted bits equal the first k pattern bits; k ranges 0..PATTERN_W-1. There are no illegal states; any out-of-range value returns to 0.
- Per accepted bit (din_valid=1), let e = PATTERN[PATTERN_W-1-k]:
  - din==e and k<PATTERN_W-1: next state = k+1, match=0.
  - din==e and k==PATTERN_W-1: match=1 combinationally in the same cycle (zero latency).
    - overlap_en=1: next state = L, the longest proper prefix of PATTERN that is also a suffix of it (L=2 for 1010).
    - overlap_en=0: next state = 0.
  - din!=e: next state = longest j ≤ k such that the last j accepted bits (the matched k-prefix plus din) equal PATTERN's first j bits (KMP fallback). Never unconditionally 0.
    - Example for 1010: k=1, din=1 -> stays 1. k=3, din=1 -> 2? No: "1011" gives prefix "1" -> 1.
- din_valid=0: state holds, match=0, counter holds.
- Precomputation: the fallback/transition table, including L, is computed at elaboration from PATTERN. No per-cycle search loops beyond PATTERN_W depth.
- overlap_en changes take effect on the next accepted bit. They have no effect on the current partial match.
- match_cnt:
  - Increments on every clk edge where match=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment: if both occur, the result is 0 (the coincident match is not counted).

Optional Feature:
- Macro SEQDET_REGOUT_EN.
- Defined: match is registered (Moore-style). It asserts one cycle after the completing bit and is glitch-free. It still asserts regardless of din_valid on that next cycle. match_cnt timing is unchanged (counts on the completing cycle). Reset clears the output flop.
- Undefined: combinational Mealy match as specified above.

Decomposition:
- Package seq_detect_pkg holds:
  - the clog2-based state width localparam helper;
  - a constant function prefix_fallback(pattern, width, k, bit) returning the next state;
  - a constant function border_len(pattern, width) returning L.
- Sub-module sat_counter (CNT_W, inc, clr, count) holds the saturating counter. It is reusable by other FSM blocks.

Test Plan:
- Default 1010, overlap_en=0, stream 1,0,1,0,1,0,1,0 all valid -> match on bits 4 and 8 only; match_cnt=2.
- Same stream with overlap_en=1 -> match on bits 4, 6, 8; match_cnt=3; state_o=2 after each match.
- Stream 1,1,0,1,0 -> match on bit 5 (fallback from k=1 on the second 1 keeps k=1); stream 1,0,1,1,0,1,0 -> match on bit 7.
- din_valid=0 inserted between each bit of 1010 -> one match, state_o holds across gaps; reset pulsed after 1,0,1 followed by 0 -> no match.
- CNT_W=2, six overlapping matches -> match_cnt saturates at 3; cnt_clr coincident with a match -> 0.
- PATTERN_W=5, PATTERN=5'b11011, overlap_en=1, stream 1,1,0,1,1,0,1,1 -> match on bits 5 and 8; with SEQDET_REGOUT_EN defined, match appears at bits 6 and 9.
